// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and helpers for the clk_divider_2 integer clock divider.
// Optional build macro used by the top level: CLK_DIV_ODD_DUTY50_EN.
// -----------------------------------------------------------------------------
package clk_div_pkg;

    // Legal range of the elaboration-time divide ratio.
    localparam int DIV_MIN = 2;
    localparam int DIV_MAX = 65536;

    // Counter width for a divide ratio n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : clk_div_pkg

// File: rtl/clk_div_counter.sv
// -----------------------------------------------------------------------------
// clk_div_counter
// Free-running modulo-N phase counter for the clock divider.
//   cnt    : current phase, runs 0 .. N-1 and wraps to 0 with no idle cycle.
//   hi_nxt : level the divided clock takes on the coming rising edge.
//            The compare is made on the phase this edge consumes, so the
//            first edge after reset release (cnt = 0) produces a high output
//            and the output is high for exactly floor(N/2) edges per period.
// -----------------------------------------------------------------------------
module clk_div_counter
    import clk_div_pkg::*;
#(
    parameter int  N     = 2,
    localparam int CNT_W = cnt_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             hi_nxt
);

    // Last phase of a period and number of high phases per period.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] HIGH    = CNT_W'(N / 2);

    // Phase counter: wrap from N-1 straight back to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Phases 0 .. HIGH-1 map to the high half of the output period.
    assign hi_nxt = (cnt < HIGH);

endmodule : clk_div_counter

// File: rtl/clk_divider_2.sv
// -----------------------------------------------------------------------------
// clk_divider_2
// Integer clock divider: f_out has a period of DIV_RATIO clk cycles and is
// always taken from a flop (plus, optionally, an OR of two flops), so it
// carries no combinational glitches.
//   Default build : high for floor(N/2) cycles, low for the rest.
//   CLK_DIV_ODD_DUTY50_EN defined : for odd N a falling-edge flop stretches
//                  the high phase by half a cycle for an exact 50% duty.
// Reset rst is asynchronous and active-low; its release must be synchronous
// to clk (there is no internal reset synchronizer).
// -----------------------------------------------------------------------------
module clk_divider_2
    import clk_div_pkg::*;
#(
    parameter int DIV_RATIO = 2
) (
    input  logic clk,
    input  logic rst,
    output logic f_out
);

    localparam int CNT_W = cnt_width(DIV_RATIO);

    // Refuse to elaborate with a ratio outside the supported range.
    if ((DIV_RATIO < DIV_MIN) || (DIV_RATIO > DIV_MAX)) begin : g_bad_ratio
        $error("clk_divider_2: DIV_RATIO=%0d outside %0d..%0d",
               DIV_RATIO, DIV_MIN, DIV_MAX);
    end

    // Phase count stays visible here for debug probes; f_out only needs
    // the compare bit.
    logic [CNT_W-1:0] cnt_unused;
    logic             hi_nxt;
    logic             f_pos_p0;

    clk_div_counter #(
        .N (DIV_RATIO)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .cnt    (cnt_unused),
        .hi_nxt (hi_nxt)
    );

    // ---- stage p0: rising-edge output register ----
    // Registered divided clock; cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_pos_p0 <= 1'b0;
        end else begin
            f_pos_p0 <= hi_nxt;
        end
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    if ((DIV_RATIO % 2) == 1) begin : g_odd_duty50
        logic f_neg_p0;

        // ---- falling-edge stretch register ----
        // Half-cycle delayed copy of the rising-edge output; OR-ing the two
        // adds half a clk period to the high phase, giving N/2 high time.
        always_ff @(negedge clk or negedge rst) begin
            if (!rst) begin
                f_neg_p0 <= 1'b0;
            end else begin
                f_neg_p0 <= f_pos_p0;
            end
        end

        assign f_out = f_pos_p0 | f_neg_p0;
    end else begin : g_even_ratio
        // Even ratios already have exact 50% duty.
        assign f_out = f_pos_p0;
    end
`else
    assign f_out = f_pos_p0;
`endif

endmodule : clk_divider_2

// File: tb/tb_clk_divider_2.sv
// -----------------------------------------------------------------------------
// tb_clk_divider_2
// Drives six divider instances (N = 2, 3, 4, 5, 7, 65536) from one clock and
// reset and compares each output, half a nanosecond after every clock edge
// and right after each asynchronous reset assertion, against a reference
// derived from the edge count since reset release. Honors
// CLK_DIV_ODD_DUTY50_EN when the bench is built with it.
// -----------------------------------------------------------------------------
`timescale 1ns / 100ps

module tb_clk_divider_2;

`ifdef CLK_DIV_ODD_DUTY50_EN
    localparam bit ODD50 = 1'b1;
`else
    localparam bit ODD50 = 1'b0;
`endif

    localparam int NUM = 6;
    localparam int NS [NUM] = '{2, 3, 4, 5, 7, 65536};

    logic           clk;
    logic           rst;
    logic [NUM-1:0] fo;

    int n_assert;
    int n_fail;

    clk_divider_2 #(.DIV_RATIO(2))     u_n2     (.clk(clk), .rst(rst), .f_out(fo[0]));
    clk_divider_2 #(.DIV_RATIO(3))     u_n3     (.clk(clk), .rst(rst), .f_out(fo[1]));
    clk_divider_2 #(.DIV_RATIO(4))     u_n4     (.clk(clk), .rst(rst), .f_out(fo[2]));
    clk_divider_2 #(.DIV_RATIO(5))     u_n5     (.clk(clk), .rst(rst), .f_out(fo[3]));
    clk_divider_2 #(.DIV_RATIO(7))     u_n7     (.clk(clk), .rst(rst), .f_out(fo[4]));
    clk_divider_2 #(.DIV_RATIO(65536)) u_n65536 (.clk(clk), .rst(rst), .f_out(fo[5]));

    // 2 ns clock period.
    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Reference: after rising edge k (k = 0 is the first edge after release)
    // the divided clock is high during the first floor(n/2) edges of each
    // n-edge period.
    function automatic logic model(input int k, input int n);
        return ((k % n) < (n / 2));
    endfunction

    // Compare all outputs. post_pos=1 means sampled just after rising edge k,
    // post_pos=0 means just after the falling edge that follows it.
    task automatic check_all(input string tag, input int k, input bit post_pos, input bit in_rst);
        for (int i = 0; i < NUM; i++) begin
            logic exp;
            int   n;
            n = NS[i];
            if (in_rst) begin
                exp = 1'b0;
            end else begin
                exp = model(k, n);
                // Odd-duty stretch: until the next falling edge the output
                // still carries the level from the previous rising edge.
                if (post_pos && ODD50 && ((n % 2) == 1) && (k >= 1))
                    exp = exp | model(k - 1, n);
            end
            n_assert++;
            assert (fo[i] === exp) else begin
                n_fail++;
                $error("FAIL %s N=%0d k=%0d observed=%b expected=%b", tag, n, k, fo[i], exp);
            end
        end
    endtask

    // Run len rising edges after a release, checking after both edges.
    task automatic run_seg(input int len);
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #0.5;
            check_all("run_pos", k, 1'b1, 1'b0);
            @(negedge clk);
            #0.5;
            check_all("run_neg", k, 1'b0, 1'b0);
        end
    endtask

    // Assert reset between edges, check the immediate drop, hold for a few
    // cycles, then release half a nanosecond before a rising edge.
    task automatic reset_hold(input int cycles);
        #0.2;
        rst = 1'b0;
        #0.1;
        check_all("async_rst", 0, 1'b0, 1'b1);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #0.5;
            check_all("rst_hold_pos", 0, 1'b0, 1'b1);
            @(negedge clk);
            #0.5;
            check_all("rst_hold_neg", 0, 1'b0, 1'b1);
        end
        rst = 1'b1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b0;

        // Reset held for 10 ns: outputs stay low across clock edges.
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #0.5;
            check_all("rst_init_pos", 0, 1'b0, 1'b1);
            @(negedge clk);
            #0.5;
            check_all("rst_init_neg", 0, 1'b0, 1'b1);
        end
        rst = 1'b1;

        // One edge (N=4 output high in cycle 1), then reset mid-period.
        run_seg(1);
        reset_hold(1);

        // Clean runs long enough to cover many N=5 periods.
        run_seg(100);
        reset_hold(2);

        // Randomized run lengths and reset hold times.
        for (int s = 0; s < 8; s++) begin
            run_seg(int'($urandom_range(3, 40)));
            reset_hold(int'($urandom_range(1, 3)));
        end

        // Full N=65536 period plus the return to high after the wrap.
        run_seg(65540);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_clk_divider_2
